// File: rtl/ray_dir_normalize_if.sv
// Handshake and data bundle between the squaring stage, the normalizer and its consumer.
interface ray_dir_normalize_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [WIDTH-1:0] dir_x;
    logic [WIDTH-1:0] dir_y;
    logic [WIDTH-1:0] dir_z;
    logic [WIDTH-1:0] sq_x;
    logic [WIDTH-1:0] sq_y;
    logic [WIDTH-1:0] sq_z;
    logic             valid_out;
    logic [WIDTH-1:0] norm_x;
    logic [WIDTH-1:0] norm_y;
    logic [WIDTH-1:0] norm_z;
    logic [WIDTH-1:0] len_out;
    logic             zero_err;

    modport master (
        output valid_in, dir_x, dir_y, dir_z, sq_x, sq_y, sq_z,
        input  ready_out, valid_out, norm_x, norm_y, norm_z, len_out, zero_err
    );

    modport slave (
        input  valid_in, dir_x, dir_y, dir_z, sq_x, sq_y, sq_z,
        output ready_out, valid_out, norm_x, norm_y, norm_z, len_out, zero_err
    );
endinterface

// File: rtl/ray_dir_normalize.sv
// Ray direction normalizer: sum of squares, bit-serial square root, then three
// bit-serial restoring divides by the length. Fixed latency, one op in flight.
module ray_dir_normalize #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned Q_BITS = 16
) (
    input logic              clk,
    input logic              reset,
    ray_dir_normalize_if.slave bus
);
    localparam int unsigned SQRT_ITERS = (WIDTH + Q_BITS + 3) / 2;
    localparam int unsigned SW   = WIDTH + 2;
    localparam int unsigned RW   = 2 * SQRT_ITERS;
    localparam int unsigned REMW = SQRT_ITERS + 2;
    localparam int unsigned DRW  = SQRT_ITERS + 1;
    localparam int unsigned CW   = ((SQRT_ITERS > WIDTH) ? SQRT_ITERS : WIDTH) + 1;
    localparam int unsigned CNTW = $clog2(CW);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1) << Q_BITS;
    localparam logic [WIDTH-1:0] LEN_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {IDLE, SUM, SQRT, DIV, DONE} state_t;

    state_t state, state_next;
    logic   load_c, sum_c, sqrt_c, div_c, done_c;
    logic   sqrt_last_c, div_last_c;

    logic [CNTW-1:0]       cnt;
    logic [WIDTH-1:0]      sq_r   [3];
    logic [WIDTH-1:0]      mag_r  [3];
    logic [2:0]            neg_r;
    logic [RW-1:0]         rad_r;
    logic [REMW-1:0]       srem_r;
    logic [SQRT_ITERS-1:0] root_r;
    logic                  zero_r;
    logic [DRW-1:0]        drem_r [3];
    logic [WIDTH-1:0]      dlo_r  [3];
    logic [WIDTH-1:0]      quo_r  [3];
    logic [2:0]            ovf_r;

    logic [SW-1:0]         sum_sq_c;
    logic [REMW-1:0]       srem_sh_c, trial_c, srem_nxt_c;
    logic [SQRT_ITERS-1:0] root_nxt_c;
    logic [DRW-1:0]        drem_sh_c  [3];
    logic [DRW-1:0]        drem_nxt_c [3];
    logic [2:0]            dbit_c;

    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    // Clamp the quotient to ONE, then restore the sign (truncation toward zero).
    function automatic logic [WIDTH-1:0] signed_norm(input logic [WIDTH-1:0] q,
                                                     input logic ovf, input logic neg);
        logic [WIDTH-1:0] m;
        m = (ovf || (q > ONE)) ? ONE : q;
        return neg ? WIDTH'(-m) : m;
    endfunction

    function automatic logic [WIDTH-1:0] sat_len(input logic [SQRT_ITERS-1:0] r);
        return (CW'(r) > CW'(LEN_MAX)) ? LEN_MAX : WIDTH'(r);
    endfunction

    assign sqrt_last_c = (cnt == CNTW'(SQRT_ITERS - 1));
    assign div_last_c  = (cnt == CNTW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.valid_in) state_next = SUM;
            SUM:     state_next = SQRT;
            SQRT:    if (sqrt_last_c) state_next = DIV;
            DIV:     if (div_last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_c = 1'b0;
        sum_c  = 1'b0;
        sqrt_c = 1'b0;
        div_c  = 1'b0;
        done_c = 1'b0;
        case (state)
            IDLE:    load_c = bus.valid_in;
            SUM:     sum_c  = 1'b1;
            SQRT:    sqrt_c = 1'b1;
            DIV:     div_c  = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // One root bit per cycle: bring down two radicand bits, try (root<<2)|1.
    always_comb begin
        sum_sq_c   = SW'(sq_r[0]) + SW'(sq_r[1]) + SW'(sq_r[2]);
        srem_sh_c  = REMW'({srem_r, rad_r[RW-1 -: 2]});
        trial_c    = REMW'({root_r, 2'b01});
        srem_nxt_c = srem_sh_c;
        root_nxt_c = SQRT_ITERS'({root_r, 1'b0});
        if (srem_sh_c >= trial_c) begin
            srem_nxt_c = srem_sh_c - trial_c;
            root_nxt_c = SQRT_ITERS'({root_r, 1'b1});
        end
    end

    // One quotient bit per cycle per lane, all lanes share the divisor root_r.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            drem_sh_c[i]  = DRW'({drem_r[i], dlo_r[i][WIDTH-1]});
            dbit_c[i]     = (drem_sh_c[i] >= DRW'(root_r));
            drem_nxt_c[i] = dbit_c[i] ? drem_sh_c[i] - DRW'(root_r) : drem_sh_c[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.ready_out <= 1'b1;
            bus.valid_out <= 1'b0;
            bus.norm_x    <= '0;
            bus.norm_y    <= '0;
            bus.norm_z    <= '0;
            bus.len_out   <= '0;
            bus.zero_err  <= 1'b0;
            cnt    <= '0;
            neg_r  <= '0;
            rad_r  <= '0;
            srem_r <= '0;
            root_r <= '0;
            zero_r <= 1'b0;
            ovf_r  <= '0;
            for (int i = 0; i < 3; i++) begin
                sq_r[i]   <= '0;
                mag_r[i]  <= '0;
                drem_r[i] <= '0;
                dlo_r[i]  <= '0;
                quo_r[i]  <= '0;
            end
        end else begin
            bus.ready_out <= (state_next == IDLE);
            bus.valid_out <= done_c;

            if (load_c) begin
                sq_r[0]  <= bus.sq_x;
                sq_r[1]  <= bus.sq_y;
                sq_r[2]  <= bus.sq_z;
                mag_r[0] <= abs_mag(bus.dir_x);
                mag_r[1] <= abs_mag(bus.dir_y);
                mag_r[2] <= abs_mag(bus.dir_z);
                neg_r    <= {bus.dir_z[WIDTH-1], bus.dir_y[WIDTH-1], bus.dir_x[WIDTH-1]};
            end

            if (sum_c) begin
                rad_r  <= RW'(sum_sq_c) << Q_BITS;
                srem_r <= '0;
                root_r <= '0;
                cnt    <= '0;
                zero_r <= (sum_sq_c == '0);
            end

            if (sqrt_c) begin
                rad_r  <= rad_r << 2;
                srem_r <= srem_nxt_c;
                root_r <= root_nxt_c;
                cnt    <= sqrt_last_c ? '0 : cnt + CNTW'(1);
                // Preload the high dividend part; if it already reaches L the quotient exceeds ONE.
                if (sqrt_last_c) begin
                    for (int i = 0; i < 3; i++) begin
                        drem_r[i] <= DRW'(mag_r[i] >> Q_BITS);
                        dlo_r[i]  <= mag_r[i] << Q_BITS;
                        quo_r[i]  <= '0;
                        ovf_r[i]  <= (CW'(mag_r[i] >> Q_BITS) >= CW'(root_nxt_c));
                    end
                end
            end

            if (div_c) begin
                cnt <= cnt + CNTW'(1);
                for (int i = 0; i < 3; i++) begin
                    drem_r[i] <= drem_nxt_c[i];
                    dlo_r[i]  <= dlo_r[i] << 1;
                    quo_r[i]  <= WIDTH'({quo_r[i], dbit_c[i]});
                end
            end

            // Zero vector masks the divide-by-zero quotients entirely.
            if (done_c) begin
                bus.zero_err <= zero_r;
                bus.len_out  <= zero_r ? '0 : sat_len(root_r);
                bus.norm_x   <= zero_r ? '0 : signed_norm(quo_r[0], ovf_r[0], neg_r[0]);
                bus.norm_y   <= zero_r ? '0 : signed_norm(quo_r[1], ovf_r[1], neg_r[1]);
                bus.norm_z   <= zero_r ? '0 : signed_norm(quo_r[2], ovf_r[2], neg_r[2]);
            end
        end
    end
endmodule

// File: tb/tb_ray_dir_normalize.sv
// Directed bench for ray_dir_normalize at WIDTH=32, Q_BITS=16 (latency 59 edges).
module tb_ray_dir_normalize;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned Q_BITS = 16;
    localparam int LAT = 59;

    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    ray_dir_normalize_if #(.WIDTH(WIDTH)) bus_if ();

    ray_dir_normalize #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int dx, input int dy, input int dz,
                         input int sx, input int sy, input int sz);
        bus_if.dir_x = WIDTH'(dx);
        bus_if.dir_y = WIDTH'(dy);
        bus_if.dir_z = WIDTH'(dz);
        bus_if.sq_x  = WIDTH'(sx);
        bus_if.sq_y  = WIDTH'(sy);
        bus_if.sq_z  = WIDTH'(sz);
    endtask

    task automatic start_op(input int dx, input int dy, input int dz,
                            input int sx, input int sy, input int sz);
        drive(dx, dy, dz, sx, sy, sz);
        bus_if.valid_in = 1'b1;
        tick();
        bus_if.valid_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Edges from the accept edge to the first valid_out sample; -1 on timeout.
    task automatic wait_valid(output int n);
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            tick();
            n++;
            got = bus_if.valid_out;
        end
        if (!got) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_if.valid_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        checks++; if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus_if.ready_out); end
        checks++; if (bus_if.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus_if.valid_out); end
        checks++; if ({bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out} !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out}); end
        checks++; if (bus_if.zero_err !== 1'b0) begin errors++; $display("FAIL reset_zero_err: got %0b expected 0", bus_if.zero_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        start_op(196608, 262144, 0, 589824, 1048576, 0);
        checks++; if (bus_if.ready_out !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %0b expected 0", bus_if.ready_out); end
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.len_out !== 32'd327680) begin errors++; $display("FAIL basic_len: got %0d expected 327680", bus_if.len_out); end
        checks++; if ($signed(bus_if.norm_x) !== 39321) begin errors++; $display("FAIL basic_nx: got %0d expected 39321", $signed(bus_if.norm_x)); end
        checks++; if ($signed(bus_if.norm_y) !== 52428) begin errors++; $display("FAIL basic_ny: got %0d expected 52428", $signed(bus_if.norm_y)); end
        checks++; if ($signed(bus_if.norm_z) !== 0) begin errors++; $display("FAIL basic_nz: got %0d expected 0", $signed(bus_if.norm_z)); end
        checks++; if (bus_if.zero_err !== 1'b0) begin errors++; $display("FAIL basic_zero_err: got %0b expected 0", bus_if.zero_err); end
        tick();
        checks++; if (bus_if.valid_out !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %0b expected 0", bus_if.valid_out); end
    endtask

    task automatic test_negative_unit();
        int n;
        start_op(-65536, 0, 0, 65536, 0, 0);
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.len_out !== 32'd65536) begin errors++; $display("FAIL neg_len: got %0d expected 65536", bus_if.len_out); end
        checks++; if ($signed(bus_if.norm_x) !== -65536) begin errors++; $display("FAIL neg_nx: got %0d expected -65536", $signed(bus_if.norm_x)); end
        checks++; if ({bus_if.norm_y, bus_if.norm_z} !== '0) begin errors++; $display("FAIL neg_nyz: got %h expected 0", {bus_if.norm_y, bus_if.norm_z}); end
    endtask

    task automatic test_diagonal();
        int n;
        start_op(65536, 65536, 65536, 65536, 65536, 65536);
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL diag_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.len_out !== 32'd113511) begin errors++; $display("FAIL diag_len: got %0d expected 113511", bus_if.len_out); end
        checks++; if ($signed(bus_if.norm_x) !== 37837) begin errors++; $display("FAIL diag_nx: got %0d expected 37837", $signed(bus_if.norm_x)); end
        checks++; if ($signed(bus_if.norm_y) !== 37837) begin errors++; $display("FAIL diag_ny: got %0d expected 37837", $signed(bus_if.norm_y)); end
        checks++; if ($signed(bus_if.norm_z) !== 37837) begin errors++; $display("FAIL diag_nz: got %0d expected 37837", $signed(bus_if.norm_z)); end
    endtask

    task automatic test_zero();
        int n;
        start_op(0, 0, 0, 0, 0, 0);
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.zero_err !== 1'b1) begin errors++; $display("FAIL zero_flag: got %0b expected 1", bus_if.zero_err); end
        checks++; if ({bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out} !== '0) begin errors++; $display("FAIL zero_outputs: got %h expected 0", {bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out}); end
    endtask

    task automatic test_back_to_back();
        int n;
        int pulses;
        int ready_bad;
        drive(196608, 262144, 0, 589824, 1048576, 0);
        bus_if.valid_in = 1'b1;
        tick();
        // Second bundle held valid for the whole busy period.
        drive(0, 0, -131072, 0, 0, 262144);
        n = 0;
        pulses = 0;
        ready_bad = 0;
        while (pulses == 0 && n < 200) begin
            tick();
            n++;
            if (bus_if.valid_out === 1'b1) pulses++;
            else if (bus_if.ready_out !== 1'b0) ready_bad++;
        end
        checks++; if (n != LAT) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", n, LAT); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d cycles with ready high expected 0", ready_bad); end
        checks++; if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_done: got %0b expected 1", bus_if.ready_out); end
        checks++; if (bus_if.len_out !== 32'd327680) begin errors++; $display("FAIL b2b_first_len: got %0d expected 327680", bus_if.len_out); end
        tick();
        bus_if.valid_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (bus_if.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_single_pulse: got %0b expected 0", bus_if.valid_out); end
        checks++; if (bus_if.ready_out !== 1'b0) begin errors++; $display("FAIL b2b_reaccept: got ready %0b expected 0", bus_if.ready_out); end
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.len_out !== 32'd131072) begin errors++; $display("FAIL b2b_second_len: got %0d expected 131072", bus_if.len_out); end
        checks++; if ($signed(bus_if.norm_z) !== -65536) begin errors++; $display("FAIL b2b_second_nz: got %0d expected -65536", $signed(bus_if.norm_z)); end
        checks++; if ({bus_if.norm_x, bus_if.norm_y} !== '0) begin errors++; $display("FAIL b2b_second_nxy: got %h expected 0", {bus_if.norm_x, bus_if.norm_y}); end
    endtask

    task automatic test_abort();
        int n;
        int early;
        int stray;
        start_op(65536, 65536, 65536, 65536, 65536, 65536);
        early = 0;
        repeat (29) begin
            tick();
            if (bus_if.valid_out === 1'b1) early++;
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (early != 0) begin errors++; $display("FAIL abort_early_valid: got %0d expected 0", early); end
        checks++; if (bus_if.ready_out !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b expected 1", bus_if.ready_out); end
        checks++; if (bus_if.valid_out !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b expected 0", bus_if.valid_out); end
        checks++; if ({bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out, bus_if.zero_err} !== '0) begin errors++; $display("FAIL abort_outputs: got %h expected 0", {bus_if.norm_x, bus_if.norm_y, bus_if.norm_z, bus_if.len_out}); end
        stray = 0;
        repeat (70) begin
            tick();
            if (bus_if.valid_out === 1'b1) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_stray_valid: got %0d expected 0", stray); end
        start_op(0, -196608, 262144, 0, 589824, 1048576);
        wait_valid(n);
        checks++; if (n != LAT) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", n, LAT); end
        checks++; if (bus_if.len_out !== 32'd327680) begin errors++; $display("FAIL abort_next_len: got %0d expected 327680", bus_if.len_out); end
        checks++; if ($signed(bus_if.norm_y) !== -39321) begin errors++; $display("FAIL abort_next_ny: got %0d expected -39321", $signed(bus_if.norm_y)); end
        checks++; if ($signed(bus_if.norm_z) !== 52428) begin errors++; $display("FAIL abort_next_nz: got %0d expected 52428", $signed(bus_if.norm_z)); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_unit();
        test_diagonal();
        test_zero();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
